// File: rtl/bsg_event_rate_pkg.sv
// rtl/bsg_event_rate_pkg.sv - shared types and constants for the event rate sampler
package bsg_event_rate_pkg;

    typedef enum logic [0:0] {eIdle, eRun} bsg_event_rate_state_e;

    // Smallest window that still leaves room for a non-boundary cycle
    localparam int min_window_lp = 2;

    // Width needed to hold values 0..x-1, never less than one bit
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_event_rate_window_timer.sv
// rtl/bsg_event_rate_window_timer.sv - modulo-window_p cycle timer with end-of-window strobe
module bsg_event_rate_window_timer
    import bsg_event_rate_pkg::*;
#(
    parameter int window_p = 1024,
    localparam int window_width_lp = safe_clog2(window_p)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [window_width_lp-1:0] last_val_lp = window_width_lp'(window_p - 1);

    logic [window_width_lp-1:0] count_q, count_d;

    assign last_o = (count_q == last_val_lp);

    // Next timer value: clear wins, otherwise advance and wrap at the window end
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    // Timer register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bsg_event_rate_sampler.sv
// rtl/bsg_event_rate_sampler.sv - per-window event counter with valid/yumi output; BSG_EVENT_RATE_SAMPLER_SAT_FLAG_EN adds sat_o
module bsg_event_rate_sampler
    import bsg_event_rate_pkg::*;
#(
    parameter int max_val_p    = 255,
    parameter int window_p     = 1024,
    parameter int drop_width_p = 8,
    localparam int count_width_lp  = safe_clog2(max_val_p + 1),
    localparam int window_width_lp = safe_clog2(window_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic                      event_i,
    output logic                      v_o,
    output logic [count_width_lp-1:0] count_o,
    input  logic                      yumi_i,
    output logic [drop_width_p-1:0]   drop_count_o
`ifdef BSG_EVENT_RATE_SAMPLER_SAT_FLAG_EN
    ,
    output logic                      sat_o
`endif
);

    localparam logic [count_width_lp:0]   max_wide_lp = (count_width_lp + 1)'(max_val_p);
    localparam logic [count_width_lp-1:0] max_val_lp  = count_width_lp'(max_val_p);

    bsg_event_rate_state_e state_q, state_d;

    logic [count_width_lp-1:0] counter_q, counter_d;
    logic                      v_q, v_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [drop_width_p-1:0]   drop_q, drop_d;

    logic                      running;
    logic                      timer_last;
    logic                      window_end;
    logic                      capture_v;
    logic                      load_out;
    logic [count_width_lp:0]   inc_sum;
    logic [count_width_lp-1:0] capture_val;

    bsg_event_rate_window_timer #(
        .window_p (window_p)
    ) timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (!running),
        .en_i    (state_q == eRun),
        .last_o  (timer_last)
    );

    // A window only progresses while in RUN with enable still high
    assign running     = (state_q == eRun) && en_i;
    assign window_end  = (state_q == eRun) && timer_last;
    assign capture_v   = window_end && en_i;
    assign load_out    = capture_v && (!v_q || yumi_i);
    assign inc_sum     = {1'b0, counter_q} + {{count_width_lp{1'b0}}, event_i};
    assign capture_val = (inc_sum > max_wide_lp) ? max_val_lp : inc_sum[count_width_lp-1:0];

    // Enable-driven IDLE/RUN sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            eIdle:   if (en_i)  state_d = eRun;
            eRun:    if (!en_i) state_d = eIdle;
            default: state_d = eIdle;
        endcase
    end

    // Saturating event counter; cleared at window end or whenever not running
    always_comb begin
        counter_d = '0;
        if (running && !window_end) begin
            counter_d = capture_val;
        end
    end

    // Output holding register and dropped-window accounting
    always_comb begin
        v_d     = v_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (load_out) begin
            v_d     = 1'b1;
            count_d = capture_val;
        end else if (capture_v) begin
            if (drop_q != {drop_width_p{1'b1}}) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (yumi_i) begin
            v_d = 1'b0;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= eIdle;
            counter_q <= '0;
            v_q       <= 1'b0;
            count_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            v_q       <= v_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
        end
    end

    assign v_o          = v_q;
    assign count_o      = count_q;
    assign drop_count_o = drop_q;

`ifdef BSG_EVENT_RATE_SAMPLER_SAT_FLAG_EN
    logic sticky_q, sticky_d;
    logic sat_q, sat_d;
    logic sat_attempt;

    // An increment attempted at the ceiling means the true count overflowed
    assign sat_attempt = event_i && (counter_q == max_val_lp);

    // Per-window sticky overflow bit and its captured copy
    always_comb begin
        sticky_d = 1'b0;
        sat_d    = sat_q;
        if (running && !window_end) begin
            sticky_d = sticky_q || sat_attempt;
        end
        if (load_out) begin
            sat_d = sticky_q || sat_attempt;
        end
    end

    // Overflow flag registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
        end
    end

    assign sat_o = sat_q;
`endif

`ifndef SYNTHESIS
    if (window_p < min_window_lp) begin : g_bad_window
        $error("bsg_event_rate_sampler: window_p must be at least 2");
    end

    // Consumer may only take a count that is being offered
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_q)
        else $error("bsg_event_rate_sampler: yumi_i asserted while v_o is low");
`endif

endmodule

// File: doc/bsg_event_rate_sampler.md
Name: bsg_event_rate_sampler

Overview:
- Measures event rate over fixed windows. Counts single-cycle event pulses across a window of window_p cycles, using a saturating, clearable event counter.
- At each window end, captures the count into an output register and clears the counter for the next window.
- Presents each captured count downstream with a valid/yumi handshake.
- Sits between raw event sources (stall/miss strobes) and a performance-monitor collector.

Parameters:
- max_val_p, 255, saturation value of the per-window event count.
- window_p, 1024, cycles per window; must be >= 2.
- count_width_lp, `BSG_SAFE_CLOG2(max_val_p+1), width of count_o (derived).
- window_width_lp, `BSG_SAFE_CLOG2(window_p), width of the window timer (derived).
- drop_width_p, 8, width of the saturating dropped-window counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous and active-high; one clock domain.
- en_i  in  1  level; sampling is enabled while high.
- event_i  in  1  event pulse; counts 1 per cycle while high.
- v_o  out  1  captured window count is valid.
- count_o  out  count_width_lp  captured count; stable while v_o is high.
- yumi_i  in  1  consumer takes count_o this cycle; legal only when v_o=1.
- drop_count_o  out  drop_width_p  windows lost because the output was still full; saturating.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, timer=0, event counter=0.
  - v_o=0, count_o=0, drop_count_o=0.
- FSM IDLE:
  - Timer and counter held at 0.
  - en_i=1 moves to RUN next cycle with timer=0.
- FSM RUN:
  - Timer increments every cycle.
  - When timer==window_p-1, that cycle is the window-end cycle and the timer wraps to 0.
  - en_i=0 in any RUN cycle, including window end, moves to IDLE next cycle. Timer and counter are cleared and the partial window is discarded: no capture, no drop. The output register is untouched.
- Event counter:
  - Outside window end: counter <= min(counter+event_i, max_val_p). Holds at max_val_p; never wraps.
- Window end with en_i=1:
  - capture = min(counter+event_i, max_val_p). The boundary-cycle event belongs to the ending window.
  - Counter clears to 0 (clear has priority; up=0).
  - The next window starts with count 0.
- Output register:
  - On capture, if v_o=0 or yumi_i=1 this cycle: count_o <= capture, v_o <= 1 next cycle. One cycle of latency from the window-end cycle.
  - Otherwise: capture discarded, count_o/v_o unchanged, drop_count_o <= min(drop+1, 2^drop_width_p-1).
  - yumi_i=1 with no capture: v_o <= 0 next cycle; count_o holds its last value.
- Handshake rules:
  - v_o must not deassert without yumi_i.
  - count_o is constant while v_o=1.
  - v_o does not depend combinationally on yumi_i.
- Simultaneous events: yumi_i and a capture in the same cycle gives back-to-back valid with no bubble.
- Assertions (simulation only):
  - yumi_i while v_o=0 is an error.
  - window_p<2 is an elaboration error.

Optional Feature:
- Macro: BSG_EVENT_RATE_SAMPLER_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_o (1 bit), qualified by v_o and loaded together with count_o.
  - A per-window sticky bit is set when an increment is attempted with the counter already at max_val_p, including at window end.
  - The sticky bit clears on window end and on the IDLE transition.
  - sat_o=1 means the true count exceeded max_val_p. It is 0 when the count equals max_val_p exactly.
  - Reset value of sat_o is 0.
- Undefined: no sat_o port and no sticky logic. All other behaviour is identical.

Decomposition:
- Shared package bsg_event_rate_pkg holds:
  - typedef enum logic [0:0] {eIdle, eRun} bsg_event_rate_state_e.
  - Constant for the minimum legal window_p (2).
- One sub-module: bsg_event_rate_window_timer. It is an asynchronous-reset modulo-window_p counter with clear_i and en_i inputs and a last_o strobe.
- The event counter stays inline. It needs asynchronous reset and the min(counter+event_i) capture path, so the team's synchronous-reset saturating counter is not reused.

Test Plan:
- window_p=8, max_val_p=5, en_i high from cycle 0, event_i every cycle, yumi_i=1 whenever v_o=1 -> v_o first high at cycle 9, count_o=5, and the same value every 8 cycles thereafter. With the macro defined, sat_o=1.
- Same config, event_i high on RUN cycles 0, 3 and 7 (7 is the window end), yumi_i=1 whenever v_o=1 -> count_o=3. The next window reports 0 when there are no events.
- yumi_i held 0 for three windows with 2 events per window -> count_o stays 2 from window 1, v_o stays 1, drop_count_o=2.
- v_o=1 and yumi_i=1 on a window-end cycle -> new count loaded next cycle, v_o stays 1, drop_count_o unchanged.
- en_i dropped at RUN cycle 4 after 3 events, re-raised 2 cycles later -> no capture from the partial window. The next capture reflects only events from the new window, 8 cycles after RUN restart.
- reset_i pulsed asynchronously mid-cycle at RUN cycle 5 with v_o=1 -> v_o, count_o and drop_count_o read 0 immediately, before the next clock edge. The state returns to IDLE and counting restarts cleanly.
